// File: rtl/dtlb_buffer.sv
// MEM-stage data TLB buffer: zero-latency vaddr->paddr on hit, stalls and
// queries TLB s1 on miss. Optional counters under DTLB_STAT_EN.
// Ports: clk, rst (sync, active-high); req_valid/req_vaddr/req_store request;
//   cp0_asid, cp0_k0 CP0 state; tlb_flush, tlbp_busy TLB control;
//   D_VPN2 -> TLB, s1_found/D_TLBEntry <- TLB;
//   paddr, uncached, stall, exc_refill/exc_invalid/exc_modify results;
//   stat_hit/stat_miss only when DTLB_STAT_EN is defined.
module dtlb_buffer #(
  parameter int ENTRIES = 2,
  parameter int STAT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  input  logic        req_store,
  input  logic [7:0]  cp0_asid,
  input  logic [2:0]  cp0_k0,
  input  logic        tlb_flush,
  input  logic        tlbp_busy,
  output logic [18:0] D_VPN2,
  input  logic        s1_found,
  input  logic [77:0] D_TLBEntry,
  output logic [31:0] paddr,
  output logic        uncached,
  output logic        stall,
  output logic        exc_refill,
  output logic        exc_invalid,
  output logic        exc_modify
`ifdef DTLB_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_hit,
  output logic [STAT_W-1:0] stat_miss
`endif
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FAULT
  } state_t;

  state_t          state;
  tlb_entry_t      ent [ENTRIES];
  logic [ENTRIES-1:0] vld;
  logic [PW-1:0]   ptr;

  tlb_entry_t  sel;
  logic        hit;
  logic        unmapped;
  logic        odd;
  logic [19:0] pfn;
  logic [2:0]  cattr;
  logic        dirty;
  logic        pvalid;
  logic        idle_req;
  logic        miss_go;

  assign unmapped = (req_vaddr[31:30] == 2'b10);
  assign odd      = req_vaddr[12];

  // Scan high to low so the lowest matching index is the one kept.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vld[i] && ent[i].vpn2 == req_vaddr[31:13] &&
          (ent[i].g || ent[i].asid == cp0_asid)) begin
        hit = 1'b1;
        sel = ent[i];
      end
    end
  end

  always_comb begin
    pfn    = odd ? sel.pfn1 : sel.pfn0;
    cattr  = odd ? sel.c1   : sel.c0;
    dirty  = odd ? sel.d1   : sel.d0;
    pvalid = odd ? sel.v1   : sel.v0;
  end

  always_comb begin
    paddr    = {pfn, req_vaddr[11:0]};
    uncached = (cattr != 3'b011);
    if (unmapped) begin
      paddr    = {3'b000, req_vaddr[28:0]};
      uncached = req_vaddr[29] ? 1'b1 : (cp0_k0 != 3'b011);
    end
  end

  assign idle_req    = req_valid && !unmapped && state == IDLE;
  assign miss_go     = idle_req && !hit;
  assign stall       = miss_go || (req_valid && state == LOOKUP);
  assign exc_refill  = req_valid && state == FAULT;
  assign exc_invalid = idle_req && hit && !pvalid;
  assign exc_modify  = idle_req && hit && pvalid && req_store && !dirty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vld    <= '0;
      ptr    <= '0;
      D_VPN2 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_go) begin
            D_VPN2 <= req_vaddr[31:13];
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          // A flush invalidates whatever the TLB returns this cycle.
          if (tlb_flush) begin
            state <= IDLE;
          end else if (!tlbp_busy) begin
            if (s1_found) begin
              ent[ptr] <= tlb_entry_t'(D_TLBEntry);
              vld[ptr] <= 1'b1;
              ptr      <= (ptr == PW'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
              state    <= IDLE;
            end else begin
              state <= req_valid ? FAULT : IDLE;
            end
          end
        end
        FAULT: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (tlb_flush) begin
        vld <= '0;
      end
    end
  end

`ifdef DTLB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (idle_req && hit && stat_hit != '1) begin
        stat_hit <= stat_hit + 1'b1;
      end
      if (miss_go && stat_miss != '1) begin
        stat_miss <= stat_miss + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dtlb_buffer.sv
// Testbench for dtlb_buffer: vector table through a scoreboard queue,
// TLB s1 behavioural model, and hand sequences for flush/busy/drop cases.
module tb_dtlb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic [7:0]  cp0_asid;
  logic [2:0]  cp0_k0;
  logic        tlb_flush;
  logic        tlbp_busy;
  logic [18:0] D_VPN2;
  logic        s1_found;
  logic [77:0] D_TLBEntry;
  logic [31:0] paddr;
  logic        uncached;
  logic        stall;
  logic        exc_refill;
  logic        exc_invalid;
  logic        exc_modify;
`ifdef DTLB_STAT_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  dtlb_buffer #(.ENTRIES(2), .STAT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vaddr(req_vaddr),
    .req_store(req_store), .cp0_asid(cp0_asid),
    .cp0_k0(cp0_k0), .tlb_flush(tlb_flush),
    .tlbp_busy(tlbp_busy), .D_VPN2(D_VPN2),
    .s1_found(s1_found), .D_TLBEntry(D_TLBEntry),
    .paddr(paddr), .uncached(uncached), .stall(stall),
    .exc_refill(exc_refill), .exc_invalid(exc_invalid),
    .exc_modify(exc_modify)
`ifdef DTLB_STAT_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
  );

  always #5 clk = ~clk;

  // TLB s1 model
  logic [77:0] tlb_mem [4];

  always_comb begin
    s1_found   = 1'b0;
    D_TLBEntry = '0;
    for (int i = 3; i >= 0; i--) begin
      if (tlb_mem[i][77:59] == D_VPN2 &&
          (tlb_mem[i][50] || tlb_mem[i][58:51] == cp0_asid)) begin
        s1_found   = 1'b1;
        D_TLBEntry = tlb_mem[i];
      end
    end
  end

  function automatic logic [77:0] mk_ent(
    input logic [18:0] vpn2, input logic [7:0] asid,
    input logic g,
    input logic [19:0] p0, input logic [2:0] c0,
    input logic d0, input logic v0,
    input logic [19:0] p1, input logic [2:0] c1,
    input logic d1, input logic v1);
    return {vpn2, asid, g, p0, c0, d0, v0, p1, c1, d1, v1};
  endfunction

  typedef struct {
    logic [31:0] va;
    logic        st;
    logic [7:0]  asid;
    logic [2:0]  k0;
    logic [31:0] pa;
    logic        unc;
    logic        chk_pa;
    int          stalls;
    logic [2:0]  exc;
  } vec_t;

  function automatic vec_t mkv(
    input logic [31:0] va, input logic st,
    input logic [7:0] asid, input logic [2:0] k0,
    input logic [31:0] pa, input logic unc,
    input logic chk_pa, input int stalls,
    input logic [2:0] exc);
    vec_t v;
    v.va = va; v.st = st; v.asid = asid; v.k0 = k0;
    v.pa = pa; v.unc = unc; v.chk_pa = chk_pa;
    v.stalls = stalls; v.exc = exc;
    return v;
  endfunction

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb [$];
  vec_t tbl [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one request, wait out the stall, compare with the
  // scoreboard head. busy_n: LOOKUP cycles with tlbp_busy;
  // flush_k: stall cycle number carrying a tlb_flush pulse.
  task automatic run(input vec_t v, input int busy_n,
                     input int flush_k, input string nm);
    vec_t e;
    int   k;
    sb.push_back(v);
    req_valid = 1'b1;
    req_vaddr = v.va;
    req_store = v.st;
    cp0_asid  = v.asid;
    cp0_k0    = v.k0;
    k = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      k++;
      if (k == 2) chk({nm, " vpn2"}, 32'(D_VPN2), 32'(v.va[31:13]));
      if (k > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout: stall stuck after %0d", nm, k);
        break;
      end
      tlbp_busy = (k >= 2 && k <= busy_n + 1);
      tlb_flush = (k == flush_k);
      @(posedge clk);
      #1;
      tlb_flush = 1'b0;
    end
    e = sb.pop_front();
    chk({nm, " stalls"}, 32'(k), 32'(e.stalls));
    chk({nm, " exc"}, 32'({exc_refill, exc_invalid, exc_modify}),
        32'(e.exc));
    if (e.chk_pa) begin
      chk({nm, " paddr"}, paddr, e.pa);
      chk({nm, " unc"}, 32'(uncached), 32'(e.unc));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tlbp_busy = 1'b0;
  endtask

  initial begin
    tlb_mem[0] = mk_ent(19'h00201, 8'd0, 1'b0,
                        20'h12345, 3'd3, 1'b1, 1'b1,
                        20'h0ABCD, 3'd2, 1'b1, 1'b1);
    tlb_mem[1] = mk_ent(19'h00400, 8'd0, 1'b1,
                        20'h00200, 3'd3, 1'b0, 1'b1,
                        20'h00300, 3'd3, 1'b1, 1'b0);
    tlb_mem[2] = mk_ent(19'h00600, 8'd5, 1'b0,
                        20'h00400, 3'd3, 1'b1, 1'b1,
                        20'h00401, 3'd3, 1'b1, 1'b1);
    tlb_mem[3] = mk_ent(19'h7FFFF, 8'hEE, 1'b0,
                        '0, 3'd0, 1'b0, 1'b0,
                        '0, 3'd0, 1'b0, 1'b0);

    //          va            st    asid   k0    pa            unc  chk stl exc
    tbl[0]  = mkv(32'h80001234, 1'b0, 8'd0, 3'd3, 32'h00001234, 1'b0, 1'b1, 0, 3'b000);
    tbl[1]  = mkv(32'h80001234, 1'b0, 8'd0, 3'd2, 32'h00001234, 1'b1, 1'b1, 0, 3'b000);
    tbl[2]  = mkv(32'hA0000010, 1'b0, 8'd0, 3'd3, 32'h00000010, 1'b1, 1'b1, 0, 3'b000);
    tbl[3]  = mkv(32'h00402008, 1'b0, 8'd0, 3'd3, 32'h12345008, 1'b0, 1'b1, 2, 3'b000);
    tbl[4]  = mkv(32'h00402008, 1'b0, 8'd0, 3'd3, 32'h12345008, 1'b0, 1'b1, 0, 3'b000);
    tbl[5]  = mkv(32'h00403008, 1'b0, 8'd0, 3'd3, 32'h0ABCD008, 1'b1, 1'b1, 0, 3'b000);
    tbl[6]  = mkv(32'h00600000, 1'b0, 8'd0, 3'd3, 32'h0,        1'b0, 1'b0, 2, 3'b100);
    tbl[7]  = mkv(32'h00800010, 1'b1, 8'd0, 3'd3, 32'h00200010, 1'b0, 1'b1, 2, 3'b001);
    tbl[8]  = mkv(32'h00801000, 1'b0, 8'd0, 3'd3, 32'h00300000, 1'b0, 1'b1, 0, 3'b010);
    tbl[9]  = mkv(32'h00800004, 1'b0, 8'd0, 3'd3, 32'h00200004, 1'b0, 1'b1, 0, 3'b000);
    tbl[10] = mkv(32'h00C00000, 1'b0, 8'd5, 3'd3, 32'h00400000, 1'b0, 1'b1, 2, 3'b000);
    tbl[11] = mkv(32'h00402008, 1'b0, 8'd0, 3'd3, 32'h12345008, 1'b0, 1'b1, 2, 3'b000);
    tbl[12] = mkv(32'h00402008, 1'b0, 8'd7, 3'd3, 32'h0,        1'b0, 1'b0, 2, 3'b100);
    tbl[13] = mkv(32'h00800004, 1'b0, 8'd7, 3'd3, 32'h00200004, 1'b0, 1'b1, 2, 3'b000);
    tbl[14] = mkv(32'h00800004, 1'b0, 8'd9, 3'd3, 32'h00200004, 1'b0, 1'b1, 0, 3'b000);
    tbl[15] = mkv(32'h00402008, 1'b1, 8'd0, 3'd3, 32'h12345008, 1'b0, 1'b1, 0, 3'b000);

    rst = 1'b1;
    req_valid = 1'b0;
    req_vaddr = '0;
    req_store = 1'b0;
    cp0_asid = '0;
    cp0_k0 = 3'd3;
    tlb_flush = 1'b0;
    tlbp_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst exc", 32'({exc_refill, exc_invalid, exc_modify}), 32'd0);
    chk("rst vpn2", 32'(D_VPN2), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run(tbl[i], 0, 0, $sformatf("vec%0d", i));
    end

    // flush, then tlbp_busy holds LOOKUP three extra cycles
    tlb_flush = 1'b1;
    @(posedge clk);
    #1;
    tlb_flush = 1'b0;
    run(mkv(32'h00402008, 1'b0, 8'd0, 3'd3, 32'h12345008,
            1'b0, 1'b1, 5, 3'b000), 3, 0, "busy3");

    // flush during LOOKUP discards the result and re-looks up
    run(mkv(32'h00C00000, 1'b0, 8'd5, 3'd3, 32'h00400000,
            1'b0, 1'b1, 4, 3'b000), 0, 2, "flush_lkp");
    // that flush also dropped the earlier page
    run(mkv(32'h00402008, 1'b0, 8'd0, 3'd3, 32'h12345008,
            1'b0, 1'b1, 2, 3'b000), 0, 0, "post_flush");

    // req_valid drops in LOOKUP: refill still completes
    req_valid = 1'b1;
    req_vaddr = 32'h00800004;
    cp0_asid = 8'd0;
    @(negedge clk);
    chk("drop_hit stall0", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("drop_hit stall1", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    run(mkv(32'h00800004, 1'b0, 8'd0, 3'd3, 32'h00200004,
            1'b0, 1'b1, 0, 3'b000), 0, 0, "drop_hit re");

    // req_valid drops in LOOKUP on a TLB miss: no refill exception
    req_valid = 1'b1;
    req_vaddr = 32'h00600000;
    @(negedge clk);
    chk("drop_miss stall0", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("drop_miss exc1", 32'(exc_refill), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_vaddr = 32'h80000000;
    @(negedge clk);
    chk("drop_miss exc2", 32'(exc_refill), 32'd0);
    chk("drop_miss stall2", 32'(stall), 32'd0);
    chk("vpn2 hold", 32'(D_VPN2), 32'h00300);
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    chk("sb empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
